// File: rtl/riscv_runctl_pkg.sv
// riscv_runctl_pkg
// Shared definitions for the run/halt sequencer of the single-cycle RISC-V
// core: FSM state encoding, halt cause codes, the instruction encodings that
// count as traps, and a helper that classifies an instruction word as a trap.
// Optional feature macro used by the importing files: RUNCTL_BREAKPOINT_EN.

package riscv_runctl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_t;

  // Halt cause codes reported on halt_cause.
  localparam logic [2:0] CAUSE_NONE       = 3'd0;
  localparam logic [2:0] CAUSE_STOP       = 3'd1;
  localparam logic [2:0] CAUSE_TRAP       = 3'd2;
  localparam logic [2:0] CAUSE_BUDGET     = 3'd3;
  localparam logic [2:0] CAUSE_BREAKPOINT = 3'd4;
  localparam logic [2:0] CAUSE_STEP       = 3'd6;

  // Instruction words that stop execution.
  localparam logic [31:0] ECALL_INSN  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  // An all-zero word is an illegal instruction; treating it as a trap stops
  // a run that has fallen off the end of the program into empty memory.
  localparam logic [31:0] NOP_ZERO    = 32'h0000_0000;

  function automatic logic is_trap(input logic [31:0] insn);
    return (insn == ECALL_INSN) || (insn == EBREAK_INSN) || (insn == NOP_ZERO);
  endfunction

endpackage

// File: rtl/runctl_halt_detect.sv
// runctl_halt_detect
// Purely combinational priority encoder that decides whether the instruction
// presented by the core in the current RUN cycle must be blocked, and why.
// Priority (high to low): stop, trap, breakpoint, budget exhausted.
// Abort is handled by the sequencer itself because it leaves to IDLE rather
// than HALTED.
// Optional feature macro: RUNCTL_BREAKPOINT_EN (adds the PC comparator).
//
// Ports:
//   stop         halt request from the host
//   instruction  instruction word the core is executing this cycle
//   pc           core PC (breakpoint build only)
//   bp_addr      breakpoint PC (breakpoint build only)
//   bp_valid     breakpoint armed (breakpoint build only)
//   bp_mask      1 = breakpoint compare allowed this cycle (breakpoint build only)
//   budget       latched instruction budget, 0 = unlimited
//   cycle_count  instructions retired so far
//   hit          1 = block this instruction and halt
//   cause        halt cause code belonging to hit

module runctl_halt_detect
  import riscv_runctl_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic          stop,
  input  logic [31:0]   instruction,
`ifdef RUNCTL_BREAKPOINT_EN
  input  logic [31:0]   pc,
  input  logic [31:0]   bp_addr,
  input  logic          bp_valid,
  input  logic          bp_mask,
`endif
  input  logic [CW-1:0] budget,
  input  logic [CW-1:0] cycle_count,
  output logic          hit,
  output logic [2:0]    cause
);

  logic trap_hit;
  logic bp_hit;
  logic budget_hit;

  assign trap_hit = is_trap(instruction);

`ifdef RUNCTL_BREAKPOINT_EN
  assign bp_hit = bp_valid && bp_mask && (pc == bp_addr);
`else
  assign bp_hit = 1'b0;
`endif

  // The compare happens before the increment, so exactly `budget`
  // instructions retire before this fires.
  assign budget_hit = (budget != '0) && (cycle_count == budget);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    hit   = 1'b0;
    cause = CAUSE_NONE;
    if (stop) begin
      hit   = 1'b1;
      cause = CAUSE_STOP;
    end else if (trap_hit) begin
      hit   = 1'b1;
      cause = CAUSE_TRAP;
    end else if (bp_hit) begin
      hit   = 1'b1;
      cause = CAUSE_BREAKPOINT;
    end else if (budget_hit) begin
      hit   = 1'b1;
      cause = CAUSE_BUDGET;
    end
  end

endmodule

// File: rtl/riscv_run_controller.sv
// riscv_run_controller
// Run/halt sequencer for the single-cycle RISC-V core. Holds the datapath in
// reset until started, gates PC / register file / data memory updates with a
// per-cycle enable, and halts on stop, trap, exhausted budget or (optionally)
// a PC breakpoint. Supports single-stepping from HALTED.
// Optional feature macro: RUNCTL_BREAKPOINT_EN (bp_addr/bp_valid ports and
// breakpoint halts with cause 4).
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   start        pulse: IDLE->RUN (fresh run) or HALTED->RUN (resume)
//   stop         halt request (ignored outside RUN)
//   step         pulse: execute exactly one instruction from HALTED
//   abort        pulse: any state -> IDLE, overrides all other inputs
//   max_cycles   instruction budget, 0 = unlimited, sampled on start from IDLE
//   pc           core PCOut
//   instruction  core Instruction
//   bp_addr      breakpoint PC (breakpoint build only)
//   bp_valid     breakpoint armed (breakpoint build only)
//   core_hold    1 = keep datapath in reset
//   core_en      1 = instruction in flight this cycle retires
//   halted       state is HALTED
//   halt_cause   last halt reason
//   cycle_count  instructions retired since start (saturating)

module riscv_run_controller
  import riscv_runctl_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          step,
  input  logic          abort,
  input  logic [CW-1:0] max_cycles,
  input  logic [31:0]   pc,
  input  logic [31:0]   instruction,
`ifdef RUNCTL_BREAKPOINT_EN
  input  logic [31:0]   bp_addr,
  input  logic          bp_valid,
`endif
  output logic          core_hold,
  output logic          core_en,
  output logic          halted,
  output logic [2:0]    halt_cause,
  output logic [CW-1:0] cycle_count
);

  run_state_t    state;
  run_state_t    state_n;
  logic [CW-1:0] budget;
  logic [2:0]    cause_n;
  logic          fresh_start;  // IDLE -> RUN: clear counters, latch budget
  logic          resume;       // HALTED -> RUN via start
  logic          det_hit;
  logic [2:0]    det_cause;

`ifdef RUNCTL_BREAKPOINT_EN
  // Set for the first RUN cycle after a resume so a run halted on a
  // breakpoint can leave that PC instead of re-hitting it forever.
  logic bp_skip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bp_skip <= 1'b0;
    else        bp_skip <= resume;
  end
`else
  logic unused_bp;
  assign unused_bp = ^{pc, resume};
`endif

  runctl_halt_detect #(.CW(CW)) u_halt_detect (
    .stop        (stop),
    .instruction (instruction),
`ifdef RUNCTL_BREAKPOINT_EN
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
    .bp_mask     (!bp_skip),
`endif
    .budget      (budget),
    .cycle_count (cycle_count),
    .hit         (det_hit),
    .cause       (det_cause)
  );

  // Next state and the combinational core controls. core_en must drop in the
  // same cycle a halt condition appears so the offending instruction never
  // retires.
  always_comb begin
    state_n     = state;
    core_en     = 1'b0;
    core_hold   = 1'b0;
    cause_n     = halt_cause;
    fresh_start = 1'b0;
    resume      = 1'b0;
    case (state)
      ST_IDLE: begin
        core_hold = 1'b1;
        if (!abort && start) begin
          state_n     = ST_RUN;
          fresh_start = 1'b1;
          cause_n     = CAUSE_NONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (det_hit) begin
          state_n = ST_HALTED;
          cause_n = det_cause;
        end else begin
          core_en = 1'b1;
        end
      end
      ST_STEP: begin
        // A step always ends in HALTED; only a trap keeps the instruction
        // from retiring. Breakpoint, stop and budget do not apply here.
        if (abort) begin
          state_n = ST_IDLE;
        end else if (is_trap(instruction)) begin
          state_n = ST_HALTED;
          cause_n = CAUSE_TRAP;
        end else begin
          core_en = 1'b1;
          state_n = ST_HALTED;
          cause_n = CAUSE_STEP;
        end
      end
      ST_HALTED: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (start) begin
          state_n = ST_RUN;
          resume  = 1'b1;
        end else if (step) begin
          state_n = ST_STEP;
        end
      end
      default: begin
        core_hold = 1'b1;
        state_n   = ST_IDLE;
      end
    endcase
  end

  assign halted = (state == ST_HALTED);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      halt_cause  <= CAUSE_NONE;
      cycle_count <= '0;
      budget      <= '0;
    end else begin
      state      <= state_n;
      halt_cause <= cause_n;
      if (fresh_start) begin
        cycle_count <= '0;
        budget      <= max_cycles;
      end else if (core_en && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CW'(1);
      end
    end
  end

endmodule

// File: doc/riscv_run_controller.md
# riscv_run_controller

Run/halt sequencer for the single-cycle RISC-V core. Holds the datapath in reset until started, gates its state updates (PC, register file, data memory writes) through a per-cycle enable, and stops execution on a stop request, a trap instruction, an exhausted cycle budget or an optional PC breakpoint. It also supports single-stepping. It sits between the testbench/host and the core's PC, RegisterFile and DataMemory write paths, and observes the core's PCOut and Instruction.

## Interface
Parameters:
- CW, 32, width of cycle counter and budget

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; IDLE→RUN (fresh run) or HALTED→RUN (resume)
- stop  in  1  level/pulse; halt request
- step  in  1  pulse; execute exactly one instruction from HALTED
- abort  in  1  pulse; any state→IDLE
- max_cycles  in  CW  instruction budget; 0 = unlimited; sampled on start from IDLE
- pc  in  32  core PCOut
- instruction  in  32  core Instruction
- bp_addr  in  32  breakpoint PC (RUNCTL_BREAKPOINT_EN only)
- bp_valid  in  1  breakpoint armed (RUNCTL_BREAKPOINT_EN only)
- core_hold  out  1  1 = keep datapath in reset
- core_en  out  1  1 = instruction in flight this cycle retires
- halted  out  1  state == HALTED
- halt_cause  out  3  last halt reason
- cycle_count  out  CW  instructions retired since start

## Operation
- States: IDLE, RUN, STEP, HALTED.
- IDLE:
  - core_hold=1, core_en=0.
  - start → RUN; cycle_count cleared; budget latched.
- RUN:
  - core_en=1 unless a halt condition hits this cycle.
  - On a hit, core_en=0 combinationally, so the current instruction does not retire, and the next state is HALTED.
- Halt conditions, priority high→low:
  - abort (→IDLE)
  - stop (cause 1)
  - trap: instruction == 0x00000073 ECALL, 0x00100073 EBREAK, or 0x00000000 (cause 2)
  - breakpoint: bp_valid && pc == bp_addr (cause 4)
  - budget: latched budget ≠ 0 && cycle_count == budget (cause 3)
- STEP:
  - One cycle with core_en=1, then HALTED with cause 6.
  - Breakpoint is ignored in STEP. Trap still blocks: core_en=0, cause 2.
- HALTED:
  - core_en=0, core_hold=0; core state is preserved.
  - start → RUN, breakpoint suppressed for the first RUN cycle.
  - step → STEP.
  - start and step in the same cycle: start wins.
  - stop is ignored.
- Trap halts are sticky: resuming re-hits the trap immediately. Only abort leaves.
- Budget halt: start resumes and halts again at once unless abort is used.
- cycle_count increments on every cycle with core_en=1 and saturates at all-ones.
- Cause codes: 0 NONE, 1 STOP, 2 TRAP, 3 BUDGET, 4 BREAKPOINT, 6 STEP. halt_cause clears to 0 on start from IDLE.

## Timing
- Reset values: state=IDLE, core_hold=1, core_en=0, halted=0, halt_cause=0, cycle_count=0, budget=0.
- start in IDLE at edge N: core_hold falls and core_en rises in cycle N+1. The first instruction retires at edge N+2.
- Halt detection is same-cycle combinational from pc/instruction to core_en. halted rises on the following edge.
- stop asserted in cycle K: the instruction in cycle K does not retire; halted=1 after edge K.
- Exactly max_cycles instructions retire before a BUDGET halt.
- abort overrides every other input in the same cycle. The core is re-held next cycle; counters are kept until the next start.
- Reset asserted mid-run: all outputs go to reset values asynchronously.

## Configuration
- RUNCTL_BREAKPOINT_EN defined: bp_addr/bp_valid ports exist, cause 4 is generated, and first-cycle suppression after resume applies.
- Undefined: both ports and the comparator are absent; cause 4 is never produced.

## Structure
- Package riscv_runctl_pkg:
  - state encoding
  - halt cause constants
  - ECALL_INSN, EBREAK_INSN, NOP_ZERO encodings
- Sub-module runctl_halt_detect: combinational priority encoder from (stop, instruction, pc, bp, budget compare) to {hit, cause}.
- Top holds the FSM, counter and budget register.

## Test plan
- Start, max_cycles=5, program of ADDIs with no trap → exactly 5 core_en cycles; halted=1; halt_cause=3; cycle_count=5.
- Run to EBREAK at pc=0x10 → core_en=0 in that cycle; halted=1; cause=2; start again → halts immediately with cause 2; abort → IDLE, core_hold=1.
- RUNCTL_BREAKPOINT_EN, bp_addr=0x08 → halt with pc=0x08, cause 4, cycle_count=2. step → one retire, pc=0x0C, cause 6. start → resumes without re-hitting 0x08.
- stop asserted for one cycle during RUN at cycle 7 → instruction 7 not retired; cycle_count=6 (with start at cycle 0); cause 1.
- start and step together in HALTED → RUN entered, not STEP.
- Reset asserted mid-RUN → core_hold=1, core_en=0, cycle_count=0 with no clock edge.
